reg_fifo: RTL and testbench

- Small synchronous FIFO for the memory stage.
- Storage is an array of word-wide enable registers, one per entry. Each entry loads only when its write-enable is asserted and holds its value otherwise.
- Sits directly upstream of the single-bit enable register stage: it buffers a data stream and presents one word per accepted read, with registered output.
- Single clock domain.

---
 rtl/reg_fifo.sv | 113 +++++++++++
 tb/tb_reg_fifo.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/reg_fifo.sv
// Small synchronous FIFO with registered read data and count-derived flags.
// Optional sticky overflow/underflow flag: define REG_FIFO_ERR_EN.
module reg_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [DEPTH-1:0]  entry_we;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_acc, rd_acc;

  // A full FIFO still accepts a write when a read frees the slot on the same edge.
  always_comb begin
    wr_acc = wr_en & (~full_q | rd_en);
    rd_acc = rd_en & ~empty_q;
  end

  always_comb begin
    entry_we = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_we[i] = wr_acc && (wr_ptr_q == ADDR_W'(i));
    end
  end

  always_comb begin
    wr_ptr_d   = wr_acc ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    rd_data_d  = rd_acc ? mem_q[rd_ptr_q] : rd_data_q;
    rd_valid_d = rd_acc;
    count_d    = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  // Storage is deliberately left out of reset.
  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    always_ff @(posedge clk) begin
      if (entry_we[g]) mem_q[g] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

`ifdef REG_FIFO_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (wr_en & full_q & ~rd_en) | (rd_en & empty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;

endmodule

// File: tb/tb_reg_fifo.sv
// Scoreboard bench for reg_fifo: a queue model predicts acceptance, flags and read order.
module tb_reg_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic [AW:0]      count;
  logic             err;

  reg_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .err      (err)
  );

  always #5 clk = ~clk;

  int unsigned      n_total = 0;
  int unsigned      n_bad   = 0;
  logic [WIDTH-1:0] mq [$];
  logic [WIDTH-1:0] sb [$];
  logic [WIDTH-1:0] last_rd = '0;
  bit               err_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_state();
    chk("count", 32'(count), 32'(mq.size()));
    chk("full",  32'(full),  32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
`ifdef REG_FIFO_ERR_EN
    chk("err", 32'(err), 32'(err_m));
`else
    chk("err", 32'(err), 32'(0));
`endif
  endtask

  task automatic clear_model();
    mq.delete();
    sb.delete();
    last_rd = '0;
    err_m   = 1'b0;
  endtask

  // One clock cycle of stimulus; model decides acceptance from its own occupancy.
  task automatic cyc(input bit w, input logic [WIDTH-1:0] d, input bit r);
    bit               m_full;
    bit               m_empty;
    bit               wacc;
    bit               racc;
    logic [WIDTH-1:0] e;
    m_full  = (mq.size() == DEPTH);
    m_empty = (mq.size() == 0);
    wacc    = w && (!m_full || r);
    racc    = r && !m_empty;
    if ((w && m_full && !r) || (r && m_empty)) err_m = 1'b1;
    if (racc) sb.push_back(mq.pop_front());
    if (wacc) mq.push_back(d);
    wr_en = w; wr_data = d; rd_en = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rd_valid", 32'(rd_valid), 32'(racc));
    if (rd_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("rd_data", 32'(rd_data), 32'(e));
      last_rd = e;
    end else begin
      chk("rd_hold", 32'(rd_data), 32'(last_rd));
    end
    chk_state();
  endtask

  task automatic reset_idle();
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_rd_data", 32'(rd_data), 32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk_state();
  endtask

  initial begin
    reset_idle();
    cyc(0, 8'h00, 0);

    // Fill then drain, plus one read on empty.
    cyc(1, 8'h11, 0); cyc(1, 8'h22, 0); cyc(1, 8'h33, 0); cyc(1, 8'h44, 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);

    reset_idle();

    // Pointer wrap: write 3, read 3, write 4, read 4.
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'h70 + i), 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1);

    // Full with simultaneous wr/rd, then a dropped overflow write.
    for (int i = 0; i < 4; i++) cyc(1, 8'(8'hA0 + i), 0);
    cyc(1, 8'hB0, 1);
    cyc(1, 8'hFF, 0);
    for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);

    // Simultaneous wr/rd on empty: only the write lands.
    cyc(1, 8'h77, 1);
    cyc(0, 8'h00, 1);

    reset_idle();

    // Mid-stream asynchronous reset between edges.
    cyc(1, 8'h01, 0); cyc(1, 8'h02, 0);
    #2;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("async_count", 32'(count), 32'(0));
    chk("async_empty", 32'(empty), 32'(1));
    chk("async_full",  32'(full),  32'(0));
    chk("async_err",   32'(err),   32'(0));
    #1;
    rst_n = 1'b1;
    cyc(1, 8'h5A, 0);
    cyc(0, 8'h00, 1);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    while (mq.size() > 0) cyc(0, 8'h00, 1);

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
